// File: rtl/load_store_unit.sv
// Load/store unit: byte-address to word-index translation, sub-word load extension,
// two-cycle read-modify-write for byte/halfword stores, and error detection/counting.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        SYS_reset,
    input  logic        LSU_req,
    input  logic        LSU_we,
    input  logic [1:0]  LSU_size,
    input  logic        LSU_unsigned,
    input  logic [31:0] LSU_addr,
    input  logic [31:0] LSU_wdata,
    output logic [31:0] LSU_rdata,
    output logic        LSU_done,
    output logic        LSU_stall,
    output logic        LSU_err,
    output logic [7:0]  LSU_err_cnt,
    output logic [31:0] DMEM_address,
    output logic [31:0] DMEM_data_in,
    output logic        DMEM_mem_write,
    output logic        DMEM_mem_read,
    input  logic [31:0] DMEM_data_out
);
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       merged_q, merged_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic        bad_access;
    logic [4:0]  shamt;
    logic [31:0] lane_data;
    logic [31:0] lane_mask;
    logic [31:0] word_idx;

    assign shamt     = {LSU_addr[1:0], 3'b000};
    assign lane_data = DMEM_data_out >> shamt;
    assign lane_mask = (LSU_size == 2'b00) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
    assign word_idx  = {{(32-ADDR_W){1'b0}}, LSU_addr[ADDR_W+1:2]};

    // Any address bit above the memory's word index makes the access out of range.
    assign bad_access = (LSU_size == 2'b11)
                     || (LSU_size == 2'b01 && LSU_addr[0])
                     || (LSU_size == 2'b10 && LSU_addr[1:0] != 2'b00)
                     || ((LSU_addr >> (ADDR_W + 2)) != 32'd0);

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        merged_d       = merged_q;
        err_cnt_d      = err_cnt_q;
        LSU_rdata      = 32'd0;
        LSU_done       = 1'b0;
        LSU_stall      = 1'b0;
        LSU_err        = 1'b0;
        DMEM_address   = 32'd0;
        DMEM_data_in   = 32'd0;
        DMEM_mem_write = 1'b0;
        DMEM_mem_read  = 1'b0;

        if (state_q == RMW_WR) begin
            DMEM_address   = {{(32-ADDR_W){1'b0}}, idx_q};
            DMEM_data_in   = merged_q;
            DMEM_mem_write = 1'b1;
            LSU_done       = 1'b1;
            state_d        = IDLE;
        end else if (LSU_req) begin
            if (bad_access) begin
                LSU_err  = 1'b1;
                LSU_done = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else if (!LSU_we) begin
                DMEM_address  = word_idx;
                DMEM_mem_read = 1'b1;
                LSU_done      = 1'b1;
                case (LSU_size)
                    2'b00:   LSU_rdata = LSU_unsigned ? {24'd0, lane_data[7:0]}
                                                      : {{24{lane_data[7]}}, lane_data[7:0]};
                    2'b01:   LSU_rdata = LSU_unsigned ? {16'd0, lane_data[15:0]}
                                                      : {{16{lane_data[15]}}, lane_data[15:0]};
                    default: LSU_rdata = DMEM_data_out;
                endcase
            end else if (LSU_size == 2'b10) begin
                DMEM_address   = word_idx;
                DMEM_data_in   = LSU_wdata;
                DMEM_mem_write = 1'b1;
                LSU_done       = 1'b1;
            end else begin
                // Sub-word store: read now, write the merged word next cycle.
                DMEM_address  = word_idx;
                DMEM_mem_read = 1'b1;
                LSU_stall     = 1'b1;
                idx_d         = LSU_addr[ADDR_W+1:2];
                merged_d      = (DMEM_data_out & ~lane_mask) | ((LSU_wdata << shamt) & lane_mask);
                state_d       = RMW_WR;
            end
        end

        // Reset forces every combinational output low so no write strobe survives into the negedge.
        if (SYS_reset) begin
            LSU_rdata      = 32'd0;
            LSU_done       = 1'b0;
            LSU_stall      = 1'b0;
            LSU_err        = 1'b0;
            DMEM_address   = 32'd0;
            DMEM_data_in   = 32'd0;
            DMEM_mem_write = 1'b0;
            DMEM_mem_read  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            merged_q  <= 32'd0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            merged_q  <= merged_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign LSU_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory (comb read, negedge write).
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        SYS_reset;
    logic        LSU_req, LSU_we, LSU_unsigned;
    logic [1:0]  LSU_size;
    logic [31:0] LSU_addr, LSU_wdata, LSU_rdata;
    logic        LSU_done, LSU_stall, LSU_err;
    logic [7:0]  LSU_err_cnt;
    logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
    logic        DMEM_mem_write, DMEM_mem_read;

    logic [31:0] mem [0:255];

    typedef struct packed {
        logic        err;
        logic        rd;
        logic        wr;
        logic        load;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] din;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .SYS_reset(SYS_reset),
        .LSU_req(LSU_req), .LSU_we(LSU_we), .LSU_size(LSU_size), .LSU_unsigned(LSU_unsigned),
        .LSU_addr(LSU_addr), .LSU_wdata(LSU_wdata), .LSU_rdata(LSU_rdata),
        .LSU_done(LSU_done), .LSU_stall(LSU_stall), .LSU_err(LSU_err), .LSU_err_cnt(LSU_err_cnt),
        .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
        .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
        .DMEM_data_out(DMEM_data_out)
    );

    always #5 clk = ~clk;

    assign DMEM_data_out = mem[DMEM_address[7:0]];
    always @(negedge clk) if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every completion pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!SYS_reset && LSU_done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("err", {31'd0, LSU_err}, {31'd0, e.err});
                check("mem_read", {31'd0, DMEM_mem_read}, {31'd0, e.rd});
                check("mem_write", {31'd0, DMEM_mem_write}, {31'd0, e.wr});
                if (e.load) check("rdata", LSU_rdata, e.rdata);
                if (!e.err) check("address", DMEM_address, e.addr);
                if (e.wr) check("data_in", DMEM_data_in, e.din);
            end
        end
    end

    // Issue one request (called #1 after a rising edge), push its expectation, wait for completion.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic eerr, input logic [31:0] erd, input logic [31:0] edin,
                          input int lat);
        exp_t e;
        int   cyc;
        e.err   = eerr;
        e.rd    = !eerr && !we;
        e.wr    = !eerr && we;
        e.load  = eerr || !we;
        e.rdata = eerr ? 32'd0 : erd;
        e.addr  = {24'd0, a[9:2]};
        e.din   = edin;
        q.push_back(e);
        LSU_req = 1'b1; LSU_we = we; LSU_size = sz; LSU_unsigned = uns;
        LSU_addr = a; LSU_wdata = wd;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            check("stall", {31'd0, LSU_stall}, {31'd0, (lat == 2 && cyc == 1)});
            if (lat == 2 && cyc == 1) check("rmw_read", {31'd0, DMEM_mem_read}, 32'd1);
            if (LSU_done) break;
            if (cyc >= 4) begin
                check("timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        LSU_req = 1'b0;
        check("latency", cyc, lat);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0101_0000 + i;
        mem[2] = 32'h1122_3344;
        mem[3] = 32'h8899_AABB;

        // Outputs stay low while reset is high, even with a live request.
        SYS_reset = 1'b1;
        LSU_req = 1'b1; LSU_we = 1'b0; LSU_size = 2'b10; LSU_unsigned = 1'b0;
        LSU_addr = 32'h0C; LSU_wdata = 32'd0;
        #12;
        check("rst_done", {31'd0, LSU_done}, 32'd0);
        check("rst_read", {31'd0, DMEM_mem_read}, 32'd0);
        check("rst_rdata", LSU_rdata, 32'd0);
        check("rst_errcnt", {24'd0, LSU_err_cnt}, 32'd0);
        LSU_req = 1'b0;
        @(posedge clk); #1;
        SYS_reset = 1'b0;
        #1;
        check("idle_outs", {LSU_rdata[0], LSU_done, LSU_stall, LSU_err, DMEM_mem_write, DMEM_mem_read}, 32'd0);
        @(posedge clk); #1;

        // Loads
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1'b0, 32'h8899_AABB, 32'd0, 1);
        do_req(1'b0, 2'b00, 1'b0, 32'h0D, 32'd0, 1'b0, 32'hFFFF_FFAA, 32'd0, 1);
        do_req(1'b0, 2'b00, 1'b1, 32'h0D, 32'd0, 1'b0, 32'h0000_00AA, 32'd0, 1);
        do_req(1'b0, 2'b01, 1'b0, 32'h0E, 32'd0, 1'b0, 32'hFFFF_8899, 32'd0, 1);
        do_req(1'b0, 2'b01, 1'b1, 32'h0E, 32'd0, 1'b0, 32'h0000_8899, 32'd0, 1);
        do_req(1'b0, 2'b00, 1'b0, 32'h0C, 32'd0, 1'b0, 32'hFFFF_FFBB, 32'd0, 1);

        // Sub-word store via read-modify-write, then readback
        do_req(1'b1, 2'b00, 1'b0, 32'h0E, 32'h1234_5677, 1'b0, 32'd0, 32'h8877_AABB, 2);
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1'b0, 32'h8877_AABB, 32'd0, 1);
        do_req(1'b1, 2'b01, 1'b0, 32'h0C, 32'hFFFF_CAFE, 1'b0, 32'd0, 32'h8877_CAFE, 2);
        do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1'b0, 32'h8877_CAFE, 32'd0, 1);

        // Word store, readback as halfword
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'hDEAD_BEEF, 1);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1'b0, 32'h0000_DEAD, 32'd0, 1);
        check("legal_cnt", {24'd0, LSU_err_cnt}, 32'd0);

        // Error cases
        do_req(1'b1, 2'b01, 1'b0, 32'h0D, 32'h55, 1'b1, 32'd0, 32'd0, 1);
        check("errcnt1", {24'd0, LSU_err_cnt}, 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h0E, 32'd0, 1'b1, 32'd0, 32'd0, 1);
        check("errcnt2", {24'd0, LSU_err_cnt}, 32'd2);
        do_req(1'b0, 2'b11, 1'b0, 32'h0C, 32'd0, 1'b1, 32'd0, 32'd0, 1);
        check("errcnt3", {24'd0, LSU_err_cnt}, 32'd3);
        do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'd0, 1'b1, 32'd0, 32'd0, 1);
        check("errcnt4", {24'd0, LSU_err_cnt}, 32'd4);

        // Reset in the middle of the write cycle of a halfword store
        LSU_req = 1'b1; LSU_we = 1'b1; LSU_size = 2'b01; LSU_unsigned = 1'b0;
        LSU_addr = 32'h08; LSU_wdata = 32'h0000_9999;
        @(posedge clk); #1;
        LSU_req = 1'b0;
        check("rmw_wr_pre", {31'd0, DMEM_mem_write}, 32'd1);
        SYS_reset = 1'b1;
        #1;
        check("rmw_wr_drop", {31'd0, DMEM_mem_write}, 32'd0);
        @(negedge clk); #1;
        SYS_reset = 1'b0;
        check("word2_kept", mem[2], 32'h1122_3344);
        check("errcnt_rst", {24'd0, LSU_err_cnt}, 32'd0);
        @(posedge clk); #1;
        check("post_rst_idle", {LSU_done, LSU_stall, DMEM_mem_write, DMEM_mem_read}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'd0, 1'b0, 32'h1122_3344, 32'd0, 1);

        // Saturation
        for (int i = 0; i < 300; i++)
            do_req(1'b1, 2'b01, 1'b0, 32'h0D, 32'd0, 1'b1, 32'd0, 32'd0, 1);
        check("sat_255", {24'd0, LSU_err_cnt}, 32'd255);
        do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'd0, 1'b1, 32'd0, 32'd0, 1);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 32'd0, 1);
        check("sat_hold", {24'd0, LSU_err_cnt}, 32'd255);

        repeat (3) @(posedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
